// File: rtl/burst_read_pipeline.sv
// Burst read engine: turns one {address, length} request into sequential memory reads
// and buffers the returned data in a small FIFO. Define BURST_READ_PIPELINE_CLAMP_EN to clamp bursts to MAX_BURST_LENGTH.
module burst_read_pipeline #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int MAX_BURST_LENGTH = 4,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] u_addr,
  input  logic [7:0]            u_length,
  input  logic                  u_addr_valid,
  output logic                  u_addr_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  d_last,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic                  busy,
  output logic                  err_len
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]                            state_q, state_d;
  logic [ADDR_WIDTH-1:0]                 addr_q, addr_d;
  logic [7:0]                            remaining_q, remaining_d;
  logic                                  pending_q, pending_d;
  logic                                  pending_last_q, pending_last_d;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [FIFO_DEPTH-1:0]                 fifo_last_q, fifo_last_d;
  logic [PW-1:0]                         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                         count_q, count_d;

  logic [7:0] len_load;
  logic [CW:0] credit_sum;
  logic accept, issue, push, pop;

`ifdef BURST_READ_PIPELINE_CLAMP_EN
  localparam logic [7:0] MAX_LEN_M1 = 8'(MAX_BURST_LENGTH - 1);
  logic len_over;
  logic err_len_q, err_len_d;
  assign len_over  = (u_length > MAX_LEN_M1);
  assign len_load  = len_over ? MAX_LEN_M1 : u_length;
  assign err_len_d = accept && len_over;
  always_ff @(posedge clk) begin
    if (rst) err_len_q <= 1'b0;
    else     err_len_q <= err_len_d;
  end
  assign err_len = !rst && err_len_q;
`else
  assign len_load = u_length;
  assign err_len  = 1'b0;
`endif

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and d_data/d_last hold while d_valid && !d_ready.
  // A read slot is only granted when the FIFO can absorb it plus the read still in flight.
  always_comb begin
    accept     = u_addr_valid && (state_q == ST_IDLE);
    credit_sum = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
    issue      = (state_q == ST_BURST) && (credit_sum < DEPTH_C);
    push       = pending_q;
    pop        = (count_q != '0) && d_ready;

    state_d        = state_q;
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    pending_d      = issue;
    pending_last_d = issue && (remaining_q == 8'd0);
    fifo_data_d    = fifo_data_q;
    fifo_last_d    = fifo_last_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;

    if (accept) begin
      addr_d      = u_addr;
      remaining_d = len_load;
      state_d     = ST_BURST;
    end
    if (issue) begin
      addr_d      = addr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - 8'd1;
      if (remaining_q == 8'd0) state_d = ST_IDLE;
    end

    if (push) begin
      fifo_data_d[wr_ptr_q] = mem_rdata;
      fifo_last_d[wr_ptr_q] = pending_last_q;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
      fifo_data_q    <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      pending_q      <= pending_d;
      pending_last_q <= pending_last_d;
      fifo_data_q    <= fifo_data_d;
      fifo_last_q    <= fifo_last_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // Outputs are forced to their idle values for the whole time rst is high.
  assign u_addr_ready = rst || (state_q == ST_IDLE);
  assign mem_re       = !rst && issue;
  assign mem_addr     = rst ? '0 : addr_q;
  assign d_valid      = !rst && (count_q != '0);
  assign d_data       = rst ? '0 : fifo_data_q[rd_ptr_q];
  assign d_last       = !rst && fifo_last_q[rd_ptr_q];
  assign busy         = !rst && ((state_q != ST_IDLE) || pending_q || (count_q != '0));

endmodule

// File: tb/tb_burst_read_pipeline.sv
// Bench for burst_read_pipeline: directed vector table, hand-written corner sequences,
// and randomized bursts with random downstream stalls checked by a scoreboard.
module tb_burst_read_pipeline;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXB = 4;
`ifdef BURST_READ_PIPELINE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] u_addr = '0;
  logic [7:0]    u_length = '0;
  logic          u_addr_valid = 1'b0;
  logic          u_addr_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] d_data;
  logic          d_last;
  logic          d_valid;
  logic          d_ready = 1'b0;
  logic          busy;
  logic          err_len;

  burst_read_pipeline #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST_LENGTH(MAXB), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .u_addr(u_addr), .u_length(u_length), .u_addr_valid(u_addr_valid),
    .u_addr_ready(u_addr_ready),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .d_data(d_data), .d_last(d_last), .d_valid(d_valid), .d_ready(d_ready),
    .busy(busy), .err_len(err_len)
  );

  // clock / reset block
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory returns its own address one cycle after the read
  always @(posedge clk) mem_rdata <= mem_addr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW:0]   exp_q[$];
  logic [DW:0]   cap_q[$];
  logic [AW-1:0] issue_q[$];
  bit            rand_ready = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW:0]   stall_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_beats(input int len);
    if (CLAMP && len > MAXB - 1) return MAXB;
    return len + 1;
  endfunction

  // scoreboard: reference beats come from address arithmetic on each accepted request
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {31'd0, d_valid, d_last, d_data}, {31'd0, 1'b1, stall_beat});
      if (u_addr_valid && u_addr_ready) begin
        int n;
        n = exp_beats(int'(u_length));
        for (int i = 0; i < n; i++) begin
          logic [AW-1:0] a;
          a = u_addr + AW'(i);
          exp_q.push_back({(i == n - 1), a});
        end
      end
      if (d_valid && d_ready) begin
        cap_q.push_back({d_last, d_data});
        if (exp_q.size() == 0) check("unexpected_beat", {31'd0, d_last, d_data}, 64'hdead);
        else check("beat", {31'd0, d_last, d_data}, {31'd0, exp_q.pop_front()});
      end
      if (mem_re) issue_q.push_back(mem_addr);
      stall_prev = d_valid && !d_ready;
      stall_beat = {d_last, d_data};
    end
  end

  // random downstream backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) d_ready = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks
  task automatic do_req(input logic [AW-1:0] a, input logic [7:0] l);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    u_addr = a; u_length = l; u_addr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (u_addr_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("req_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    u_addr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_dvalid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (d_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("dvalid_timeout", 0, 1);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    int            beats;
    logic [DW-1:0] first;
    logic [DW-1:0] last_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h0000_0100, 8'd0, 1, 32'h0000_0100, 32'h0000_0100};
    vecs[1] = '{32'h0000_0010, 8'd3, 4, 32'h0000_0010, 32'h0000_0013};
    vecs[2] = '{32'hFFFF_FFFE, 8'd3, 4, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[3] = '{32'h0000_2000, 8'd9, (CLAMP ? 4 : 10), 32'h0000_2000,
                (CLAMP ? 32'h0000_2003 : 32'h0000_2009)};
    vecs[4] = '{32'h0000_5550, 8'd1, 2, 32'h0000_5550, 32'h0000_5551};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  u_addr_ready, 1);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_d_valid", d_valid, 0);
    check("rst_d_last", d_last, 0);
    check("rst_d_data", d_data, 0);
    check("rst_busy",   busy, 0);
    check("rst_err_len", err_len, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single beat latency: accept N, mem_re N+1, d_valid N+3
    d_ready = 1'b1;
    do_req(32'h100, 8'd0);
    @(negedge clk);
    check("lat_mem_re",   mem_re, 1);
    check("lat_mem_addr", mem_addr, 32'h100);
    check("lat_ready_lo", u_addr_ready, 0);
    check("lat_busy",     busy, 1);
    @(negedge clk);
    check("lat_n2_valid", d_valid, 0);
    @(negedge clk);
    check("lat_n3_valid", d_valid, 1);
    check("lat_n3_data",  d_data, 32'h100);
    check("lat_n3_last",  d_last, 1);
    wait_idle();

    // vector table
    for (int v = 0; v < 5; v++) begin
      cap_q.delete();
      do_req(vecs[v].addr, vecs[v].len);
      wait_idle();
      check("vec_beats", cap_q.size(), vecs[v].beats);
      if (cap_q.size() > 0) begin
        check("vec_first", cap_q[0][DW-1:0], vecs[v].first);
        check("vec_last_data", cap_q[cap_q.size()-1][DW-1:0], vecs[v].last_data);
        check("vec_last_flag", cap_q[cap_q.size()-1][DW], 1);
        for (int j = 0; j < cap_q.size() - 1; j++) check("vec_mid_flag", cap_q[j][DW], 0);
      end
    end

    // address wrap on the read port
    issue_q.delete();
    do_req(32'hFFFF_FFFE, 8'd3);
    wait_idle();
    check("wrap_issues", issue_q.size(), 4);
    if (issue_q.size() == 4) begin
      check("wrap_a0", issue_q[0], 32'hFFFF_FFFE);
      check("wrap_a1", issue_q[1], 32'hFFFF_FFFF);
      check("wrap_a2", issue_q[2], 32'h0);
      check("wrap_a3", issue_q[3], 32'h1);
    end

    // err_len pulse
    do_req(32'h7000, 8'd9);
    @(negedge clk);
    check("err_len_pulse", err_len, CLAMP);
    @(negedge clk);
    check("err_len_drop", err_len, 0);
    wait_idle();
    do_req(32'h7100, 8'd2);
    @(negedge clk);
    check("err_len_inrange", err_len, 0);
    wait_idle();

    // backpressure: FIFO fills, reads stop, nothing lost
    d_ready = 1'b0;
    cap_q.delete();
    issue_q.delete();
    do_req(32'h300, 8'd7);
    wait_dvalid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data_hold", d_data, 32'h300);
    end
    check("bp_mem_re_off", mem_re, 0);
    check("bp_issues", issue_q.size(), 4);
    check("bp_busy", busy, 1);
    @(posedge clk);
    #1;
    d_ready = 1'b1;
    wait_idle();
    check("bp_beats", cap_q.size(), 8);

    // reset during beat 2, new request right after release
    do_req(32'h40, 8'd3);
    wait_dvalid();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cap_q.delete();
    u_addr = 32'h80; u_length = 8'd1; u_addr_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", d_valid, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_ready", u_addr_ready, 1);
    @(posedge clk);
    #1;
    u_addr_valid = 1'b0;
    wait_idle();
    check("mid_rst_beats", cap_q.size(), 2);
    if (cap_q.size() > 0) check("mid_rst_first", cap_q[0][DW-1:0], 32'h80);

    // randomized bursts with random stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_req($urandom, 8'($urandom_range(0, 12)));
    end
    wait_idle();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    d_ready = 1'b1;
    wait_idle();
    check("final_exp_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
